nrdiv: RTL and testbench

- Sequential unsigned non-restoring divider. It is the inverse operation of the team's radix-4 Booth multiplier and uses the same byte-serial bus protocol.
- Operands arrive over one shared input bus: dividend first, then divisor.
- Quotient then remainder leave over one registered output bus, with a one-cycle end_o strobe.
- Sits beside the multiplier in the arithmetic unit, under the same sequencer.

---
 rtl/nrdiv_pkg.sv | 17 +
 rtl/nrdiv_step.sv | 26 ++
 rtl/nrdiv.sv | 133 +++++++++++++
 tb/tb_nrdiv.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nrdiv_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// State width matches the Booth multiplier so both sit under one sequencer.
package nrdiv_pkg;

    localparam int unsigned DefWidth = 8;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLoadM = 4'd1,
        StIter  = 4'd2,
        StCorr  = 4'd3,
        StOutQ  = 4'd4,
        StOutR  = 4'd5,
        StDone  = 4'd6
    } state_e;

endpackage

// File: rtl/nrdiv_step.sv
// One combinational non-restoring iteration: shift {A,Q} left, then add or
// subtract the divisor depending on the sign of the old partial remainder.
module nrdiv_step
    import nrdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] m_ext;

    always_comb begin
        // The old sign bit is shifted out; the add/sub wraps modulo 2^(WIDTH+1)
        a_sh  = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
        m_ext = {1'b0, m_i};
        a_o   = a_i[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
        q_o   = {q_i[WIDTH-2:0], ~a_o[WIDTH]};
    end

endmodule

// File: rtl/nrdiv.sv
// Sequential unsigned non-restoring divider with a byte-serial operand bus:
// dividend then divisor in, quotient then remainder out, one-cycle end_o strobe.
module nrdiv
    import nrdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] inbus_i,
    input  logic             begin_i,
    output logic             end_o,
    output logic [WIDTH-1:0] outbus_o,
    output logic             dbz_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             end_q, end_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;

    nrdiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a_i(a_q),
        .q_i(q_q),
        .m_i(m_q),
        .a_o(step_a),
        .q_o(step_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        out_d   = out_q;
        end_d   = 1'b0;
        dbz_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (begin_i) begin
                    q_d     = inbus_i;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = StLoadM;
                end
            end
            StLoadM: begin
                m_d = inbus_i;
                if (inbus_i == '0) begin
                    // Divide by zero: quotient all-ones, remainder is the dividend
                    q_d     = '1;
                    a_d     = {1'b0, q_q};
                    flag_d  = 1'b1;
                    state_d = StOutQ;
                end else begin
                    state_d = StIter;
                end
            end
            StIter: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StCorr;
                end
            end
            StCorr: begin
                if (a_q[WIDTH]) begin
                    a_d = a_q + {1'b0, m_q};
                end
                state_d = StOutQ;
            end
            StOutQ: begin
                out_d   = q_q;
                state_d = StOutR;
            end
            StOutR: begin
                out_d   = a_q[WIDTH-1:0];
                end_d   = 1'b1;
                dbz_d   = flag_q;
                state_d = StDone;
            end
            StDone: begin
                flag_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            out_q   <= '0;
            end_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            out_q   <= out_d;
            end_q   <= end_d;
            dbz_q   <= dbz_d;
        end
    end

    assign outbus_o = out_q;
    assign end_o    = end_q;
    assign dbz_o    = dbz_q;

endmodule

// File: tb/tb_nrdiv.sv
// Bench for nrdiv: a protocol-timeline model checked every cycle, plus
// directed literal cases and a randomized operand sweep.
module tb_nrdiv;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] inbus_i;
    logic       begin_i;
    logic       end_o;
    logic [7:0] outbus_o;
    logic       dbz_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc_fail_prints = 0;
    int ends_seen = 0;

    nrdiv #(
        .WIDTH(8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inbus_i (inbus_i),
        .begin_i (begin_i),
        .end_o   (end_o),
        .outbus_o(outbus_o),
        .dbz_o   (dbz_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: divides with / and %, and schedules outputs on the
    // documented timeline (quotient at edge 11 or 2, remainder one edge later).
    logic       busy_m = 1'b0;
    int         t_m = 0;
    int         lat_m = 11;
    logic [7:0] dvd_m, q_m, r_m;
    logic       dz_m;
    logic [7:0] exp_out = 8'h00;
    logic       exp_end = 1'b0;
    logic       exp_dbz = 1'b0;
    int         begins_m = 0;
    int         aborts_m = 0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if (busy_m) aborts_m <= aborts_m + 1;
            busy_m  <= 1'b0;
            exp_out <= 8'h00;
            exp_end <= 1'b0;
            exp_dbz <= 1'b0;
        end else if (!busy_m) begin
            if (begin_i) begin
                busy_m   <= 1'b1;
                t_m      <= 0;
                dvd_m    <= inbus_i;
                begins_m <= begins_m + 1;
            end
        end else begin
            t_m <= t_m + 1;
            if (t_m == 0) begin
                lat_m <= (inbus_i == 8'h00) ? 2 : 11;
                if (inbus_i == 8'h00) begin
                    q_m  <= 8'hFF;
                    r_m  <= dvd_m;
                    dz_m <= 1'b1;
                end else begin
                    q_m  <= dvd_m / inbus_i;
                    r_m  <= dvd_m % inbus_i;
                    dz_m <= 1'b0;
                end
            end else if (t_m == lat_m - 1) begin
                exp_out <= q_m;
            end else if (t_m == lat_m) begin
                exp_out <= r_m;
                exp_end <= 1'b1;
                exp_dbz <= dz_m;
            end else if (t_m == lat_m + 1) begin
                exp_end <= 1'b0;
                exp_dbz <= 1'b0;
                busy_m  <= 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        n_tests++;
        if (outbus_o !== exp_out || end_o !== exp_end || dbz_o !== exp_dbz) begin
            n_fail++;
            if (n_cyc_fail_prints < 20) begin
                n_cyc_fail_prints++;
                $display("FAIL cycle_model t=%0t got out=%h end=%b dbz=%b, want out=%h end=%b dbz=%b",
                         $time, outbus_o, end_o, dbz_o, exp_out, exp_end, exp_dbz);
            end
        end
        if (end_o === 1'b1) ends_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Entered at the negedge after the divisor edge; returns at the negedge
    // after the DONE edge, when the DUT is idle again.
    task automatic wait_result(input string name, input logic [7:0] a, input logic [7:0] b,
                               input bit noise, input bit lit,
                               input logic [7:0] eq, input logic [7:0] er);
        logic [7:0] prev;
        bit seen;
        int lat;
        prev = outbus_o;
        seen = 0;
        lat  = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (noise) begin
                begin_i = 1'($urandom);
                inbus_i = 8'($urandom);
            end
            if (end_o === 1'b1) begin
                seen = 1;
                lat  = i;
                break;
            end
            prev = outbus_o;
        end
        check({name, "_end_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_latency"}, 32'(lat), (b == 8'h00) ? 32'd1 : 32'd10);
            if (b == 8'h00) begin
                check({name, "_dbz_q"}, 32'(prev), 32'hFF);
                check({name, "_dbz_r"}, 32'(outbus_o), 32'(a));
                check({name, "_dbz_flag"}, 32'(dbz_o), 32'd1);
            end else begin
                check({name, "_invariant"}, 32'(prev) * 32'(b) + 32'(outbus_o), 32'(a));
                check({name, "_rem_lt_div"}, 32'(outbus_o < b), 32'd1);
                check({name, "_dbz_flag"}, 32'(dbz_o), 32'd0);
            end
            if (lit) begin
                check({name, "_lit_q"}, 32'(prev), 32'(eq));
                check({name, "_lit_r"}, 32'(outbus_o), 32'(er));
            end
        end
        @(negedge clk_i);
        check({name, "_end_fall"}, {30'd0, end_o, dbz_o}, 32'd0);
        if (noise) begin_i = 1'b0;
    endtask

    task automatic do_div(input string name, input logic [7:0] a, input logic [7:0] b,
                          input bit noise, input bit lit,
                          input logic [7:0] eq, input logic [7:0] er);
        begin_i = 1'b1;
        inbus_i = a;
        @(negedge clk_i);
        begin_i = 1'b0;
        inbus_i = b;
        @(negedge clk_i);
        wait_result(name, a, b, noise, lit, eq, er);
    endtask

    initial begin
        rst_i   = 1'b0;
        begin_i = 1'b0;
        inbus_i = 8'h00;
        repeat (2) @(negedge clk_i);
        check("reset_outs", {22'd0, outbus_o, end_o, dbz_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        do_div("d100_7", 8'd100, 8'd7, 1'b0, 1'b1, 8'h0E, 8'h02);
        do_div("d255_1", 8'd255, 8'd1, 1'b0, 1'b1, 8'hFF, 8'h00);
        do_div("d200_0", 8'd200, 8'd0, 1'b0, 1'b1, 8'hFF, 8'hC8);

        // begin_i held high throughout: the first result must be unaffected
        begin_i = 1'b1;
        inbus_i = 8'd100;
        @(negedge clk_i);
        inbus_i = 8'd7;
        @(negedge clk_i);
        wait_result("hold_100_7", 8'd100, 8'd7, 1'b0, 1'b1, 8'h0E, 8'h02);
        inbus_i = 8'd81;
        @(negedge clk_i);
        begin_i = 1'b0;
        inbus_i = 8'd9;
        @(negedge clk_i);
        wait_result("b2b_81_9", 8'd81, 8'd9, 1'b0, 1'b1, 8'h09, 8'h00);

        do_div("d5_9", 8'd5, 8'd9, 1'b0, 1'b1, 8'h00, 8'h05);

        // Abort 100/7 with reset just after edge 5
        begin_i = 1'b1;
        inbus_i = 8'd100;
        @(posedge clk_i);
        #1;
        begin_i = 1'b0;
        inbus_i = 8'd7;
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("abort_outs", {22'd0, outbus_o, end_o, dbz_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        do_div("d13_4", 8'd13, 8'd4, 1'b0, 1'b1, 8'h03, 8'h01);

        for (int k = 0; k < 2500; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            do_div("rand", ra, rb, 1'b1, 1'b0, 8'h00, 8'h00);
        end

        repeat (3) @(negedge clk_i);
        check("end_count", 32'(ends_seen), 32'(begins_m - aborts_m));
        check("abort_count", 32'(aborts_m), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
